rr_shared_reg_arb: RTL and testbench

Round-robin arbiter that shares one DW-bit shared register write port among N requesters. Each winner owns the register for a burst of beats, during which its data is written on every clock edge. The block sits between the small-circuit stimulus and datapath modules and the register they contend for. It sequences grant, burst counting and release, so that updates to the register are strictly ordered and non-overlapping.

---
 rtl/rr_shared_reg_arb_pkg.sv | 18 +
 rtl/rr_shared_reg_arb_if.sv | 32 +++
 rtl/rr_shared_reg_arb_pick.sv | 33 +++
 rtl/rr_shared_reg_arb.sv | 147 ++++++++++++++
 tb/tb_rr_shared_reg_arb.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_shared_reg_arb_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
// Optional burst truncation is enabled by defining ARB_TIMEOUT_EN.
package rr_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_N  = 4;
  localparam int ARB_OW = $clog2(ARB_N);

  // LSB position of field idx in a vector of packed w-bit fields
  function automatic int lsb_of(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rr_shared_reg_arb_if.sv
// Request/grant/data bundle between requesters and the shared-register arbiter.
// The trunc signal exists only when ARB_TIMEOUT_EN is defined.
interface rr_shared_reg_arb_if #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int LW = 4
);
  localparam int OW = $clog2(N);

  logic [N-1:0]    req;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            busy;
  logic [OW-1:0]   owner;
  logic [N-1:0]    done;
  logic [DW-1:0]   shr_q;
`ifdef ARB_TIMEOUT_EN
  logic            trunc;

  modport master (output req, req_len, req_data,
                  input  gnt, busy, owner, done, shr_q, trunc);
  modport slave  (input  req, req_len, req_data,
                  output gnt, busy, owner, done, shr_q, trunc);
`else
  modport master (output req, req_len, req_data,
                  input  gnt, busy, owner, done, shr_q);
  modport slave  (input  req, req_len, req_data,
                  output gnt, busy, owner, done, shr_q);
`endif

endinterface

// File: rtl/rr_shared_reg_arb_pick.sv
// Rotate-priority encoder: first set request scanning ptr, ptr+1, ... mod N.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N  = ARB_N,
  parameter int OW = ARB_OW
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] ptr,
  output logic          any,
  output logic [OW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [OW:0]    off;
  logic [OW:0]    sum;

  always_comb begin
    dbl = {req, req};
    rot = N'(dbl >> ptr);
    any = |req;
    off = '0;
    // descending scan so the lowest rotated position wins
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = (OW+1)'(k);
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (OW+1)'(N)) sum = sum - (OW+1)'(N);
    idx = sum[OW-1:0];
  end

endmodule

// File: rtl/rr_shared_reg_arb.sv
// Round-robin owner of one shared register write port, burst per grant.
// Define ARB_TIMEOUT_EN to cap bursts at MAX_BEATS and report truncation.
//
// state   | meaning
// ST_IDLE | no owner, arbitrate every cycle
// ST_BUSY | owner writes req_data each cycle until its last beat
module rr_shared_reg_arb
  import rr_arb_pkg::*;
#(
  parameter int N  = ARB_N,
  parameter int DW = 8,
  parameter int LW = 4
`ifdef ARB_TIMEOUT_EN
  , parameter int MAX_BEATS = 8
`endif
) (
  input  logic          clk,
  input  logic          rst,
  rr_shared_reg_arb_if.slave bus
);

  localparam int OW = $clog2(N);

  arb_state_e    state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;
  logic [DW-1:0] shr_reg_q, shr_reg_d;
  logic [N-1:0]  pick_req;
  logic          any;
  logic [OW-1:0] win;
  logic          last;
  logic          grant;
  logic          cut;
`ifdef ARB_TIMEOUT_EN
  localparam int BW = $clog2(MAX_BEATS + 1);
  logic [BW-1:0] beats_q, beats_d;
  logic          trunc_q, trunc_d;
`endif

  // the finishing owner is excluded so a held request cannot monopolise the port
  assign pick_req = (state_q == ST_BUSY) ? (bus.req & ~gnt_q) : bus.req;

  rr_pick #(.N(N), .OW(OW)) u_pick (
    .req (pick_req),
    .ptr (ptr_q),
    .any (any),
    .idx (win)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    shr_reg_d = shr_reg_q;
    grant     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    beats_d   = beats_q;
    trunc_d   = 1'b0;
    cut       = (beats_q == BW'(MAX_BEATS - 1)) && (cnt_q != '0);
`else
    cut       = 1'b0;
`endif
    last      = (cnt_q == '0) || cut;
    case (state_q)
      ST_IDLE: grant = any;
      ST_BUSY: begin
        if (!bus.req[owner_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else begin
          shr_reg_d = bus.req_data[lsb_of(int'(owner_q), DW) +: DW];
          if (last) begin
            done_d = gnt_q;
`ifdef ARB_TIMEOUT_EN
            trunc_d = cut;
`endif
            grant = any;
            if (!any) begin
              state_d = ST_IDLE;
              gnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - LW'(1);
`ifdef ARB_TIMEOUT_EN
            beats_d = beats_q + BW'(1);
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (grant) begin
      state_d = ST_BUSY;
      gnt_d   = N'(1) << win;
      owner_d = win;
      cnt_d   = bus.req_len[lsb_of(int'(win), LW) +: LW];
      ptr_d   = (win == OW'(N - 1)) ? '0 : win + OW'(1);
`ifdef ARB_TIMEOUT_EN
      beats_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      shr_reg_q <= '0;
`ifdef ARB_TIMEOUT_EN
      beats_q   <= '0;
      trunc_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      shr_reg_q <= shr_reg_d;
`ifdef ARB_TIMEOUT_EN
      beats_q   <= beats_d;
      trunc_q   <= trunc_d;
`endif
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.busy  = |gnt_q;
  assign bus.owner = owner_q;
  assign bus.done  = done_q;
  assign bus.shr_q = shr_reg_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.trunc = trunc_q;
`endif

endmodule

// File: tb/tb_rr_shared_reg_arb.sv
// Bench for rr_shared_reg_arb: directed scenarios plus random traffic against
// a transaction-level model of grants, beats and completions.
module tb_rr_shared_reg_arb;

  localparam int N         = 4;
  localparam int DW        = 8;
  localparam int LW        = 4;
  localparam int MAX_BEATS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]          req = '0;
  logic [N-1:0][LW-1:0]  len = '0;
  logic [N-1:0][DW-1:0]  dat = '0;

  int n_chk  = 0;
  int n_fail = 0;

  // model: current owner (-1 none), beats left in its burst, priority start
  int            m_own  = -1;
  int            m_left = 0;
  int            m_ptr  = 0;
  int            m_last = 0;
  logic [DW-1:0] m_shr  = '0;
  logic [N-1:0]  m_done = '0;
  logic          m_trunc = 1'b0;
  logic          m_cut   = 1'b0;

  always #5 clk = ~clk;

  rr_shared_reg_arb_if #(.N(N), .DW(DW), .LW(LW)) bus();

  assign bus.req      = req;
  assign bus.req_len  = len;
  assign bus.req_data = dat;

  rr_shared_reg_arb #(
    .N(N), .DW(DW), .LW(LW)
`ifdef ARB_TIMEOUT_EN
    , .MAX_BEATS(MAX_BEATS)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic grant(input int w);
    m_own  = w;
    m_last = w;
    m_ptr  = (w + 1) % N;
    m_left = int'(len[w]) + 1;
    m_cut  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    if (m_left > MAX_BEATS) begin
      m_left = MAX_BEATS;
      m_cut  = 1'b1;
    end
`endif
  endtask

  task automatic model_edge();
    int w;
    m_done  = '0;
    m_trunc = 1'b0;
    if (rst) begin
      m_own = -1; m_ptr = 0; m_last = 0; m_shr = '0;
      return;
    end
    if (m_own < 0) begin
      w = pick(req, m_ptr);
      if (w >= 0) grant(w);
    end else if (!req[m_own]) begin
      m_own = -1;
    end else begin
      m_shr = dat[m_own];
      m_left--;
      if (m_left == 0) begin
        m_done[m_own] = 1'b1;
        m_trunc = m_cut;
        w = pick(req & ~(N'(1) << m_own), m_ptr);
        if (w >= 0) grant(w);
        else m_own = -1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    eg = (m_own >= 0) ? (N'(1) << m_own) : '0;
    chk("gnt",   32'(bus.gnt),   32'(eg));
    chk("busy",  32'(bus.busy),  32'(m_own >= 0));
    chk("owner", 32'(bus.owner), 32'(m_last));
    chk("done",  32'(bus.done),  32'(m_done));
    chk("shr_q", 32'(bus.shr_q), 32'(m_shr));
`ifdef ARB_TIMEOUT_EN
    chk("trunc", 32'(bus.trunc), 32'(m_trunc));
`endif
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #2;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int gcount [N];
    int hi;
    int seen;

    // reset state
    do_reset();
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_shr", 32'(bus.shr_q), 32'h0);

    // single burst, len 2
    req = 4'b0010; len[1] = 4'd2; dat[1] = 8'hA5;
    cycle(); chk("sb_gnt_c1", 32'(bus.gnt), 32'h2);
    cycle(); chk("sb_shr_c2", 32'(bus.shr_q), 32'hA5);
    cycle(); chk("sb_gnt_c3", 32'(bus.gnt), 32'h2);
    cycle(); chk("sb_done_c4", 32'(bus.done), 32'h2);
             chk("sb_gnt_c4", 32'(bus.gnt), 32'h0);
    req = '0;
    cycle();

    // contention, len 0
    do_reset();
    req = 4'b0101; len[0] = '0; len[2] = '0; dat[0] = 8'h11; dat[2] = 8'h22;
    cycle(); chk("ct_gnt_c1", 32'(bus.gnt), 32'h1);
    cycle(); chk("ct_gnt_c2", 32'(bus.gnt), 32'h4);
             chk("ct_shr_c2", 32'(bus.shr_q), 32'h11);
             chk("ct_done_c2", 32'(bus.done), 32'h1);
    cycle(); chk("ct_shr_c3", 32'(bus.shr_q), 32'h22);
             chk("ct_done_c3", 32'(bus.done), 32'h4);
    req = '0;
    cycle();

    // fairness, all requesting with len 0
    do_reset();
    req = 4'b1111; len = '0;
    for (int i = 0; i < N; i++) gcount[i] = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      chk("fair_order", 32'(bus.gnt), 32'(N'(1) << (c % N)));
      for (int i = 0; i < N; i++) if (bus.gnt[i]) gcount[i]++;
    end
    for (int i = 0; i < N; i++) chk("fair_count", 32'(gcount[i]), 32'd2);
    req = '0;
    cycle();

    // abort after two beats
    do_reset();
    req = 4'b1000; len[3] = 4'd5; dat[3] = 8'h30;
    cycle();
    dat[3] = 8'h31; cycle();
    dat[3] = 8'h32; cycle();
    req = '0; dat[3] = 8'h33;
    cycle(); chk("ab_gnt", 32'(bus.gnt), 32'h0);
             chk("ab_shr", 32'(bus.shr_q), 32'h32);
             chk("ab_done", 32'(bus.done), 32'h0);
    cycle(); chk("ab_idle", 32'(bus.busy), 32'h0);

    // reset during beat 2 of a len-3 burst
    do_reset();
    req = 4'b0100; len[2] = 4'd3; dat[2] = 8'h44;
    cycle(); cycle();
    rst = 1'b1;
    cycle(); chk("rm_gnt", 32'(bus.gnt), 32'h0);
             chk("rm_shr", 32'(bus.shr_q), 32'h0);
             chk("rm_done", 32'(bus.done), 32'h0);
    rst = 1'b0; req = 4'b1111; len = '0;
    cycle(); chk("rm_ptr", 32'(bus.gnt), 32'h1);
    req = '0;
    cycle();

    // long burst: capped at MAX_BEATS only with the timeout build
    do_reset();
    req = 4'b0001; len[0] = 4'd15;
    hi = 0; seen = 0;
    for (int c = 0; c < 30 && seen == 0; c++) begin
      cycle();
      if (bus.gnt[0]) hi++;
      if (bus.done[0]) seen = 1;
    end
    chk("to_done_seen", 32'(seen), 32'd1);
`ifdef ARB_TIMEOUT_EN
    chk("to_len", 32'(hi), 32'(MAX_BEATS));
    chk("to_trunc", 32'(bus.trunc), 32'd1);
`else
    chk("to_len", 32'(hi), 32'd16);
`endif
    req = '0;
    cycle();

    // random traffic
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) req[i] = 1'b1;
        end else if (m_done[i] && $urandom_range(0, 1) == 0) begin
          req[i] = 1'b0;
        end else if ($urandom_range(0, 49) == 0) begin
          req[i] = 1'b0;
        end
        dat[i] = DW'($urandom);
        len[i] = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 15))
                                             : LW'($urandom_range(0, 2));
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
